register_sequencer: RTL
=======================

# register_sequencer

Control-side sequencer for the datapath register file: accepts one instruction at a time over a start/busy/done handshake and issues the 3-bit register opcodes that the X and Y registers execute, plus the ULA function select. Opcodes use the register command encoding: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100. It sits between the instruction source and the registers: datax feeds the X register input, and the ULA output feeds the Y register input.

## Interface
- WIDTH, 4, data width of datax and of the instruction data field (shift count uses all WIDTH bits)
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  instruction request, sampled only in IDLE
- op  input  3  instruction code, sampled with start
- data  input  WIDTH  immediate value / shift count, sampled with start
- Tx  output  3  X register command
- Ty  output  3  Y register command
- Tula  output  3  ULA select: ADD 000, SUB 001, PASSX 010; 000 when unused
- datax  output  WIDTH  latched immediate, held stable until next accepted start
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse ending every accepted instruction
- err  output  1  high together with done for an illegal op, else 0

## Operation
- States: IDLE, EXEC, SHIFT, DONE (2-bit state register), plus latched op, latched data, WIDTH-bit shift counter.
- IDLE: all commands HOLD, busy=0. start=1 at an edge latches op/data into registers, datax<=data; next state EXEC for ops 000,001,010,101,110; SHIFT for 011/100 with data≠0 (counter<=data); DONE for 011/100 with data=0 and for op 111.
- Instruction set (commands asserted for exactly one cycle in EXEC unless noted):
  - 000 LOADX: Tx=LOAD (X<=datax).
  - 001 ADD: Tula=ADD, Ty=LOAD (Y<=X+Y, 4-bit wrap in ULA).
  - 010 SUB: Tula=SUB, Ty=LOAD (Y<=Y−X, wrap).
  - 011 SHR: Ty=SHIFTR for each SHIFT cycle, count = data (1..2^WIDTH−1).
  - 100 SHL: Ty=SHIFTL for each SHIFT cycle, count = data.
  - 101 CLR: Tx=RESET and Ty=RESET in the same cycle.
  - 110 MOVE: Tula=PASSX, Ty=LOAD (Y<=X).
  - 111 illegal: no command other than HOLD issued; DONE asserts err=1.
- EXEC -> DONE after one cycle.
- SHIFT: counter decrements each cycle; leaves to DONE on the cycle counter=1; exactly data shift commands issued.
- DONE: done=1, busy=1, all commands HOLD; next state IDLE. start during DONE, EXEC, SHIFT is ignored (not queued).
- Outputs Tx/Ty/Tula/busy/done/err decoded from state and latched op only (Moore); no combinational path from start/op/data to any output.

## Timing
- Reset (async, any state, mid-instruction included): state IDLE, Tx=Ty=Tula=000, datax=0, busy=0, done=0, err=0, counter=0; an instruction in flight is abandoned with no done pulse.
- Acceptance at edge k: commands active during cycle k+1 (EXEC), registers act at edge k+2, done high during cycle k+2, IDLE in cycle k+3; next start sampled at edge k+3 earliest. Single-command instruction: 3-cycle throughput.
- Shift of n≥1: SHIFT cycles k+1..k+n, done in cycle k+n+1.
- Shift of 0 and illegal op: done (and err) in cycle k+1, no register command ever non-HOLD.
- datax changes only at an accepting edge.

## Test plan
- Reset mid-SHL (data=5, after 2 shift cycles): assert rst -> outputs immediately 000/0, no done; after release start LOADX data=9 -> Tx=001 one cycle, datax=9, done 2 cycles after start edge.
- ADD then SUB sequence: LOADX 3, ADD, SUB -> Tula=000 with Ty=001 for one cycle, then Tula=001 with Ty=001; each done exactly once, busy contiguous per instruction.
- SHR data=4'hF -> exactly 15 consecutive cycles Ty=010, done in 16th cycle after acceptance; SHL data=0 -> no Ty activity, done next cycle.
- CLR -> Tx=100 and Ty=100 in the same single cycle, Tula=000.
- op=111 data=7 -> done=1 and err=1 same cycle, all commands HOLD throughout, err low afterwards.
- start held high continuously with MOVE -> accepted every 3 cycles only; starts during EXEC/DONE ignored; Tula=010, Ty=001 once per acceptance.

Source files
------------

// File: rtl/register_sequencer.sv
// register_sequencer
// Control sequencer for the X/Y datapath register file. Accepts one
// instruction at a time (start/busy/done handshake) and issues 3-bit
// register commands for X and Y plus the ULA function select.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - instruction request, sampled only while idle
//   op     - instruction code (3 bits), sampled with start
//   data   - immediate / shift count (WIDTH bits), sampled with start
//   Tx     - X register command (HOLD/LOAD/SHIFTR/SHIFTL/RESET)
//   Ty     - Y register command
//   Tula   - ULA select (ADD/SUB/PASSX), ADD when unused
//   datax  - latched immediate feeding the X register input
//   busy   - high from the cycle after acceptance through the done cycle
//   done   - one-cycle pulse closing every accepted instruction
//   err    - high together with done for an illegal op
module register_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [2:0]       Tx,
  output logic [2:0]       Ty,
  output logic [2:0]       Tula,
  output logic [WIDTH-1:0] datax,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CMD_W = 3;

  // Register command encoding
  localparam logic [CMD_W-1:0] CMD_HOLD   = 3'b000;
  localparam logic [CMD_W-1:0] CMD_LOAD   = 3'b001;
  localparam logic [CMD_W-1:0] CMD_SHIFTR = 3'b010;
  localparam logic [CMD_W-1:0] CMD_SHIFTL = 3'b011;
  localparam logic [CMD_W-1:0] CMD_RESET  = 3'b100;

  // ULA select encoding
  localparam logic [CMD_W-1:0] ULA_ADD   = 3'b000;
  localparam logic [CMD_W-1:0] ULA_SUB   = 3'b001;
  localparam logic [CMD_W-1:0] ULA_PASSX = 3'b010;

  // Instruction codes
  localparam logic [2:0] OP_LOADX = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_CLR   = 3'b101;
  localparam logic [2:0] OP_MOVE  = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   datax_q, datax_d;
  logic [CMD_W-1:0]   tx_q, tx_d;
  logic [CMD_W-1:0]   ty_q, ty_d;
  logic [CMD_W-1:0]   tula_q, tula_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Next-state, instruction latch and shift counter
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    datax_d = datax_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          datax_d = data;
          unique case (op)
            OP_SHR, OP_SHL: begin
              // A zero-length shift skips straight to completion.
              if (data != '0) begin
                state_d = ST_SHIFT;
                cnt_d   = data;
              end else begin
                state_d = ST_DONE;
              end
            end
            OP_ILL:  state_d = ST_DONE;
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_SHIFT: begin
        cnt_d = cnt_q - WIDTH'(1);
        if (cnt_q == WIDTH'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from the upcoming state and latched op, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    tx_d   = CMD_HOLD;
    ty_d   = CMD_HOLD;
    tula_d = ULA_ADD;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_DONE) && (op_d == OP_ILL);
    unique case (state_d)
      ST_EXEC: begin
        unique case (op_d)
          OP_LOADX: tx_d = CMD_LOAD;
          OP_ADD: begin
            tula_d = ULA_ADD;
            ty_d   = CMD_LOAD;
          end
          OP_SUB: begin
            tula_d = ULA_SUB;
            ty_d   = CMD_LOAD;
          end
          OP_CLR: begin
            tx_d = CMD_RESET;
            ty_d = CMD_RESET;
          end
          OP_MOVE: begin
            tula_d = ULA_PASSX;
            ty_d   = CMD_LOAD;
          end
          default: ;
        endcase
      end
      ST_SHIFT: ty_d = (op_d == OP_SHR) ? CMD_SHIFTR : CMD_SHIFTL;
      default: ;
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      datax_q <= '0;
      tx_q    <= CMD_HOLD;
      ty_q    <= CMD_HOLD;
      tula_q  <= ULA_ADD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      datax_q <= datax_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tula_q  <= tula_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Tx    = tx_q;
  assign Ty    = ty_q;
  assign Tula  = tula_q;
  assign datax = datax_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
